regfile_bypass: RTL

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_bypass_if.sv | 26 ++
 rtl/regfile_bypass.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_bypass_if.sv
// Register file access bundle: one write port, two read ports and a Ready flag.
// The master drives addresses and write data; the slave (the register file)
// returns read data and Ready.
interface regfile_bypass_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] WriteRegister;
  logic              RegWrite;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic              Ready;

  modport master (
    output WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, Ready
  );

  modport slave (
    input  WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, Ready
  );
endinterface

// File: rtl/regfile_bypass.sv
// Two-read / one-write register file with a post-reset clear sweep.
// After reset a CLEAR state zeros one entry per clock; Ready rises one edge
// after the sweep finishes. Reads are combinational and optionally forward a
// same-cycle legal write.
module regfile_bypass #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  regfile_bypass_if.slave  bus
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);
  // When the address space is exactly filled, every address is in range.
  localparam bit FULL_MAP = (DEPTH >= (1 << ADDR_W));

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              wr_in_range;
  logic              wr_ok;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];

  assign rd_addr[0] = bus.ReadRegister1;
  assign rd_addr[1] = bus.ReadRegister2;

  generate
    if (FULL_MAP) begin : g_wr_full
      assign wr_in_range = 1'b1;
    end else begin : g_wr_part
      assign wr_in_range = (int'(bus.WriteRegister) < DEPTH);
    end
  endgenerate

  // A write only lands when the file is ready, in range and not aimed at a
  // hardwired zero register; the same qualifier gates forwarding.
  assign wr_ok = ready_q && bus.RegWrite && wr_in_range &&
                 !(ZR && (bus.WriteRegister == '0));

  // Sweep pointer advances every CLEAR edge; the last entry hands over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == LAST_IDX) begin
        state_d = RUN;
      end
    end
  end

  // Control state; Ready lags the RUN state by one edge so the entry edge
  // itself never accepts a write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= (state_q == RUN);
    end
  end

  // Storage: the sweep and normal writes share a single write port.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state_q == CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_ok) begin
        mem_q[bus.WriteRegister] <= bus.WriteData;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic in_range;
      logic rd_ok;
      logic hit;

      if (FULL_MAP) begin : g_full
        assign in_range = 1'b1;
      end else begin : g_part
        assign in_range = (int'(rd_addr[gi]) < DEPTH);
      end

      assign rd_ok = ready_q && in_range && !(ZR && (rd_addr[gi] == '0));
      assign hit   = BP && wr_ok && (bus.WriteRegister == rd_addr[gi]);

      // Read mux: zero when not readable, else forwarded or stored data.
      always_comb begin
        rd_data[gi] = '0;
        if (rd_ok) begin
          rd_data[gi] = hit ? bus.WriteData : mem_q[rd_addr[gi]];
        end
      end
    end
  endgenerate

  assign bus.ReadData1 = rd_data[0];
  assign bus.ReadData2 = rd_data[1];
  assign bus.Ready     = ready_q;

endmodule
